// File: rtl/acc_pkg.sv
// Shared definitions for the 16-bit accumulator processor control path.
// Holds the opcode and funct constants, the ALU operation codes, the datapath
// mux select encodings, the control state encoding and the control word
// struct that the decoder drives.
package acc_pkg;

    // Opcodes
    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_LI    = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQZ  = 4'h4;
    localparam logic [3:0] OP_J     = 4'h5;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // ALU operations (R-type funct values 0..7 map directly onto these)
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_PASSB = 4'd7;

    // PCSrc mux
    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    // ACCSrc mux
    localparam logic [1:0] ACC_ALU = 2'd0;
    localparam logic [1:0] ACC_MEM = 2'd1;
    localparam logic [1:0] ACC_IMM = 2'd2;

    // ALUSrcB mux
    localparam logic [1:0] SRCB_ACC   = 2'd0;
    localparam logic [1:0] SRCB_ONE   = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_DELTA = 2'd3;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXEC_R  = 4'd2,
        S_EXEC_LI = 4'd3,
        S_ADDR    = 4'd4,
        S_MEM_RD  = 4'd5,
        S_MEM_WB  = 4'd6,
        S_MEM_WR  = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_HALT    = 4'd15
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       addr_src;
        logic       acc_write;
        logic [1:0] acc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       halted;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_legal(input logic [3:0] op);
        return (op == OP_RTYPE) || (op == OP_LI) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQZ) || (op == OP_J) || (op == OP_HALT);
    endfunction

    // States that hold a memory access open and therefore run the wait counter.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/acc_ctrl_decode.sv
// Control word decoder: combinational map from the current control state
// plus its few qualifiers to the datapath control strobes.
// Ports:
//   state     in  current control state
//   opcode    in  instruction opcode (only matters in DECODE)
//   funct     in  R-type ALU function (only matters in EXEC_R)
//   mem_ready in  memory handshake (qualifies IRWrite/PCWrite in FETCH)
//   acc_zero  in  accumulator == 0 (qualifies PCWrite in BRANCH)
//   ctrl      out control word
module acc_ctrl_decode
    import acc_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] opcode,
    input  logic [3:0] funct,
    input  logic       mem_ready,
    input  logic       acc_zero,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                // Fetch from PC while the ALU forms PC+1 for the PC update.
                ctrl.mem_read  = 1'b1;
                ctrl.addr_src  = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_ONE;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Branch target PC+sext(Imm) lands in ALUOut speculatively.
                ctrl.alu_src_a  = 1'b0;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = ALU_ADD;
                ctrl.illegal_op = !op_legal(opcode);
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_ACC;
                ctrl.alu_op    = funct;
                ctrl.acc_src   = ACC_ALU;
                // Only funct 0..7 are defined ALU operations.
                ctrl.acc_write  = !funct[3];
                ctrl.illegal_op = funct[3];
            end
            S_EXEC_LI: begin
                ctrl.acc_write = 1'b1;
                ctrl.acc_src   = ACC_IMM;
            end
            S_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_DELTA;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.addr_src = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.acc_write = 1'b1;
                ctrl.acc_src   = ACC_MEM;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.addr_src  = 1'b1;
            end
            S_BRANCH: begin
                ctrl.pc_src   = PC_ALUOUT;
                ctrl.pc_write = acc_zero;
            end
            S_JUMP: begin
                ctrl.pc_src   = PC_JUMP;
                ctrl.pc_write = 1'b1;
            end
            S_HALT: begin
                ctrl.halted = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/acc_control_fsm.sv
// Multicycle control unit for the 16-bit accumulator processor.
// Sequences fetch/decode/execute/memory/writeback, holds memory accesses
// until MemReady, and halts with a sticky MemTimeout if an access waits
// MEM_WAIT_MAX consecutive cycles.
// Ports:
//   CLK, Reset          clock, async active-high reset (all outputs forced 0)
//   Opcode, funct       instruction register fields
//   AccZero, MemReady   datapath status / memory handshake
//   PCWrite..ALUOp      datapath control strobes and mux selects
//   Halted, IllegalOp   core stopped / one-cycle undefined-instruction pulse
//   MemTimeout          sticky memory timeout flag
//   State               debug state code
module acc_control_fsm
    import acc_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [3:0] Opcode,
    input  logic [3:0] funct,
    input  logic       AccZero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       AddrSrc,
    output logic       ACCWrite,
    output logic [1:0] ACCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUOp,
    output logic       Halted,
    output logic       IllegalOp,
    output logic       MemTimeout,
    output logic [3:0] State
);

    // Count value seen on the cycle whose miss would reach MEM_WAIT_MAX.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_t     state, state_next;
    logic [7:0] wait_cnt;
    logic       timeout_q;
    logic       wait_expired;
    ctrl_t      ctrl, ctrl_out;

    // A completing access (MemReady=1) never expires, so completion wins
    // when it coincides with the last allowed wait cycle.
    assign wait_expired = is_wait_state(state) && !MemReady && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:   if (MemReady) state_next = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:      state_next = S_EXEC_R;
                    OP_LI:         state_next = S_EXEC_LI;
                    OP_LW, OP_SW:  state_next = S_ADDR;
                    OP_BEQZ:       state_next = S_BRANCH;
                    OP_J:          state_next = S_JUMP;
                    OP_HALT:       state_next = S_HALT;
                    default:       state_next = S_FETCH;
                endcase
            end
            S_EXEC_R, S_EXEC_LI, S_MEM_WB, S_BRANCH, S_JUMP:
                state_next = S_FETCH;
            // IR is only written in FETCH, so Opcode is still the LW/SW here.
            S_ADDR:    state_next = (Opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  if (MemReady) state_next = S_MEM_WB;
            S_MEM_WR:  if (MemReady) state_next = S_FETCH;
            S_HALT:    state_next = S_HALT;
            default:   state_next = S_FETCH;
        endcase
        if (wait_expired) state_next = S_HALT;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state)
                wait_cnt <= '0;
            else if (is_wait_state(state) && !MemReady)
                wait_cnt <= wait_cnt + 8'd1;
            if (wait_expired)
                timeout_q <= 1'b1;
        end
    end

    acc_ctrl_decode u_decode (
        .state     (state),
        .opcode    (Opcode),
        .funct     (funct),
        .mem_ready (MemReady),
        .acc_zero  (AccZero),
        .ctrl      (ctrl)
    );

    // Reset gates the outputs directly so strobes drop the moment it rises,
    // without waiting for the state register to settle.
    assign ctrl_out = Reset ? '0 : ctrl;

    assign PCWrite    = ctrl_out.pc_write;
    assign PCSrc      = ctrl_out.pc_src;
    assign IRWrite    = ctrl_out.ir_write;
    assign MemRead    = ctrl_out.mem_read;
    assign MemWrite   = ctrl_out.mem_write;
    assign AddrSrc    = ctrl_out.addr_src;
    assign ACCWrite   = ctrl_out.acc_write;
    assign ACCSrc     = ctrl_out.acc_src;
    assign ALUSrcA    = ctrl_out.alu_src_a;
    assign ALUSrcB    = ctrl_out.alu_src_b;
    assign ALUOp      = ctrl_out.alu_op;
    assign Halted     = ctrl_out.halted;
    assign IllegalOp  = ctrl_out.illegal_op;
    assign MemTimeout = timeout_q & ~Reset;
    assign State      = Reset ? 4'd0 : state;

endmodule

// File: doc/acc_control_fsm.md
# acc_control_fsm

Multicycle control unit for the 16-bit accumulator processor. It sequences fetch, decode, execute, memory and writeback by driving the datapath control strobes (PC, instruction register, accumulator, ALU and memory) from the `Opcode`/`funct` fields the instruction register presents. It holds memory accesses until the memory handshake completes. It sits between the instruction register outputs and the datapath muxes and enables.

## Interface
Parameters:
- `MEM_WAIT_MAX`, default 15: memory-wait cycles before `MemTimeout` is raised; range 1..255.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `Reset`  in  1  asynchronous, active-high; one clock, async active-high reset.
- `Opcode`  in  4  from instruction register; valid from DECODE onward.
- `funct`  in  4  from instruction register; ALU function for R-type.
- `AccZero`  in  1  accumulator == 0.
- `MemReady`  in  1  memory handshake; access completes in the cycle it is 1.
- `PCWrite`  out  1  load PC.
- `PCSrc`  out  2  0 = ALU result, 1 = ALUOut register, 2 = {PC[15:12], Imm}.
- `IRWrite`  out  1  load instruction register.
- `MemRead`, `MemWrite`  out  1 each  memory strobes.
- `AddrSrc`  out  1  0 = PC, 1 = ALUOut.
- `ACCWrite`  out  1  load accumulator.
- `ACCSrc`  out  2  0 = ALU result, 1 = memory data, 2 = sign-extended Imm.
- `ALUSrcA`  out  1  0 = PC, 1 = register `RegSelect`.
- `ALUSrcB`  out  2  0 = ACC, 1 = constant 1, 2 = sext(Imm), 3 = zext(Delta).
- `ALUOp`  out  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 pass-B.
- `Halted`  out  1  core stopped.
- `IllegalOp`  out  1  one-cycle pulse on an undefined opcode or funct.
- `MemTimeout`  out  1  sticky until reset.
- `State`  out  4  debug state code.

## Operation
- Opcodes: 0000 R-type, 0001 LI, 0010 LW, 0011 SW, 0100 BEQZ, 0101 J, 1111 HALT. All other opcodes are illegal.
- FETCH: `MemRead`=1, `AddrSrc`=0, ALU computes PC+1 (`ALUSrcA`=0, `ALUSrcB`=1, add).
  - When `MemReady`=1, assert `IRWrite`=1 and `PCWrite`=1 (`PCSrc`=0), then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: ALU computes PC+sext(Imm) into ALUOut. Branch to the state for the opcode.
  - Illegal opcode: pulse `IllegalOp` and return to FETCH.
- EXEC_R: `ALUSrcA`=1, `ALUSrcB`=0, `ALUOp`=funct[3:0], `ACCWrite`=1, `ACCSrc`=0, then FETCH.
  - funct ≥ 8: no `ACCWrite`, pulse `IllegalOp`.
- EXEC_LI: `ACCWrite`=1, `ACCSrc`=2, then FETCH.
- ADDR: ALU computes Reg[RegSelect]+zext(Delta) into ALUOut. Go to MEM_RD for LW, MEM_WR for SW.
- MEM_RD: `MemRead`=1, `AddrSrc`=1. Wait for `MemReady`, then go to MEM_WB.
- MEM_WB: `ACCWrite`=1, `ACCSrc`=1, then FETCH.
- MEM_WR: `MemWrite`=1, `AddrSrc`=1. Wait for `MemReady`, then FETCH.
- BRANCH: `PCWrite`=`AccZero`, `PCSrc`=1, then FETCH.
- JUMP: `PCWrite`=1, `PCSrc`=2, then FETCH.
- HALT: `Halted`=1, all strobes 0. Remains in HALT until `Reset`.
- Wait counter: counts consecutive cycles with `MemReady`=0 in FETCH, MEM_RD or MEM_WR.
  - When the count reaches `MEM_WAIT_MAX`, set `MemTimeout` and go to HALT.
  - The counter clears on every state change.

## Timing
- All outputs are Moore, decoded from the state register. Exceptions: `IRWrite` and `PCWrite` in FETCH are qualified by `MemReady`, and `PCWrite` in BRANCH is qualified by `AccZero`.
- Minimum cycles per instruction, with zero memory wait:
  - R, LI, BEQZ, J: 3.
  - SW: 4.
  - LW: 5.
  - Each wait cycle adds 1.
- `Reset` high: state = FETCH, wait counter = 0, `MemTimeout` = 0. While `Reset` is high, every output is forced 0 and `State` = 0.
- Reset mid-access (MEM_WR or MEM_RD): strobes drop asynchronously. The first cycle after release is FETCH.
- `MemReady` already 1 on entry to a wait state: the access completes in that same cycle.
- `MemReady` is ignored outside FETCH, MEM_RD and MEM_WR.
- `MemReady` rises in the same cycle the counter would hit `MEM_WAIT_MAX`: completion wins and no timeout is raised.

## Structure
- Shared package `acc_pkg` holds:
  - opcode constants (`OP_RTYPE`…`OP_HALT`);
  - the ALUOp encoding;
  - the `PCSrc`, `ACCSrc` and `ALUSrcB` mux encodings;
  - the state enumeration: FETCH = 0, DECODE = 1, EXEC_R = 2, EXEC_LI = 3, ADDR = 4, MEM_RD = 5, MEM_WB = 6, MEM_WR = 7, BRANCH = 8, JUMP = 9, HALT = 15.
- One sub-module, `acc_ctrl_decode`: combinational map from state plus qualifiers to the control word. The top level holds the state register, next-state logic and wait counter.

## Test plan
- R-type add (`Opcode`=0000, `funct`=0000), `MemReady` tied 1 → states 0,1,2,0. `ACCWrite`=1 only in EXEC_R, with `ALUOp`=0.
- LW (`Opcode`=0010) with `MemReady` low for 3 cycles in MEM_RD → states 0,1,4,5,5,5,5,6,0. `ACCSrc`=1 in MEM_WB.
- BEQZ (`Opcode`=0100): `AccZero`=1 gives `PCWrite`=1 with `PCSrc`=1 in BRANCH; `AccZero`=0 gives `PCWrite`=0 in BRANCH.
- `Opcode`=1010 → `IllegalOp` pulses for exactly one cycle in DECODE, next state FETCH. `Opcode`=1111 → `Halted`=1, held for 20 cycles.
- `MemReady` held 0 in FETCH with `MEM_WAIT_MAX`=15 → `MemTimeout`=1 after 15 cycles, state goes to HALT. `Reset` clears both.
- `Reset` asserted mid MEM_WR → `MemWrite` drops immediately. After release, state = 0 with `MemRead`=1.
